fx_itc: RTL and testbench

Parametrised PC-FX interrupt control unit. It is the next generation of the gate-array ITC, generalised to NSRC sources. Each source has a per-source edge/level mode, latched pending bits with write-1-to-clear, programmable levels and registered priority resolution. It sits between device interrupt lines and the V810 CINT/CINTVn inputs. Its registers are reached via the gate-array I/O decode.

---
 rtl/fx_itc.sv | 176 +++++++++++++++++
 tb/tb_fx_itc.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fx_itc.sv
// rtl/fx_itc.sv - parametrised PC-FX interrupt control unit
//
// Purpose: collects NSRC device interrupt lines, latches them in level or
// rising-edge mode, applies a mask and per-source levels, and presents the
// registered winning request to the V810 CINT/CINTVn inputs.
//
// Optional feature macro: ITC_SYNC_EN (2-flop CE-gated input synchroniser).
//
// Ports:
//   CLK     system clock
//   RESn    asynchronous active-low reset
//   CE      clock enable, all state advances only when high
//   SRC     raw interrupt request lines, active-high
//   CS      register select
//   WR      write strobe (qualified by CS)
//   RD      read strobe (qualified by CS)
//   ADDR    register word index
//   DI      write data
//   DO      combinational read data, 0 unless CS&RD
//   CINT    interrupt request to CPU
//   CINTVn  {1'b0, ~level} of the winning source
//   CSRC    index of the winning source

module fx_itc #(
   parameter int NSRC = 7,
   parameter int LVLW = 3
) (
   input  logic            CLK,
   input  logic            RESn,
   input  logic            CE,
   input  logic [NSRC-1:0] SRC,
   input  logic            CS,
   input  logic            WR,
   input  logic            RD,
   input  logic [3:0]      ADDR,
   input  logic [15:0]     DI,
   output logic [15:0]     DO,
   output logic            CINT,
   output logic [LVLW:0]   CINTVn,
   output logic [3:0]      CSRC
);

   logic [NSRC-1:0] src_in;
   logic [NSRC-1:0] s;
   logic [NSRC-1:0] s_d;
   logic [NSRC-1:0] pend;
   logic [NSRC-1:0] pend_nxt;
   logic [NSRC-1:0] imr;
   logic [NSRC-1:0] imode;
   logic [LVLW-1:0] ilr [NSRC];
   logic [LVLW-1:0] lvl_q;

   logic            wr;
   logic            wr_isr;
   logic            wr_imr;
   logic            wr_imode;
   logic [NSRC-1:0] isr_clr;
   logic [NSRC-1:0] imode_chg;
   logic [NSRC-1:0] rise;
   logic [NSRC-1:0] eisr;

   logic            win_found;
   logic [LVLW-1:0] win_lvl;
   logic [3:0]      win_idx;

   // Not every DI bit lands in a register for every parameter set.
   logic            unused_di;
   assign unused_di = ^DI;

`ifdef ITC_SYNC_EN
   logic [NSRC-1:0] sync1;
   logic [NSRC-1:0] sync2;

   always_ff @(posedge CLK or negedge RESn) begin
      if (!RESn) begin
         sync1 <= '0;
         sync2 <= '0;
      end else if (CE) begin
         sync1 <= SRC;
         sync2 <= sync1;
      end
   end

   assign src_in = sync2;
`else
   assign src_in = SRC;
`endif

   assign wr       = CS & WR;
   assign wr_isr   = wr && (ADDR == 4'd0);
   assign wr_imr   = wr && (ADDR == 4'd1);
   assign wr_imode = wr && (ADDR == 4'd2);

   assign isr_clr   = wr_isr   ? DI[NSRC-1:0] : '0;
   // A mode change on a source discards whatever it had latched.
   assign imode_chg = wr_imode ? (DI[NSRC-1:0] ^ imode) : '0;
   assign rise      = s & ~s_d;

   // Edge sources: a new rising edge beats a simultaneous W1C.
   assign pend_nxt = ~imode_chg &
                     ((imode & (rise | (pend & ~isr_clr))) | (~imode & s));

   assign eisr = pend & ~imr;

   // Strict '>' keeps the lowest index on ties; starting from level 0
   // means a source programmed to level 0 can never win.
   always_comb begin
      win_found = 1'b0;
      win_lvl   = '0;
      win_idx   = '0;
      for (int i = 0; i < NSRC; i++) begin
         if (eisr[i] && (ilr[i] > win_lvl)) begin
            win_found = 1'b1;
            win_lvl   = ilr[i];
            win_idx   = 4'(i);
         end
      end
   end

   always_ff @(posedge CLK or negedge RESn) begin
      if (!RESn) begin
         s     <= '0;
         s_d   <= '0;
         pend  <= '0;
         imr   <= '1;
         imode <= '0;
         for (int i = 0; i < NSRC; i++) begin
            ilr[i] <= LVLW'((1 << LVLW) - 1 - (i % 4));
         end
         CINT  <= 1'b0;
         lvl_q <= '0;
         CSRC  <= '0;
      end else if (CE) begin
         s    <= src_in;
         s_d  <= s;
         pend <= pend_nxt;
         if (wr_imr) begin
            imr <= DI[NSRC-1:0];
         end
         if (wr_imode) begin
            imode <= DI[NSRC-1:0];
         end
         for (int i = 0; i < NSRC; i++) begin
            if (wr && (ADDR == 4'(4 + i / 4))) begin
               ilr[i] <= DI[(i % 4) * 4 +: LVLW];
            end
         end
         CINT  <= win_found;
         lvl_q <= win_lvl;
         CSRC  <= win_idx;
      end
   end

   assign CINTVn = {1'b0, ~lvl_q};

   always_comb begin
      DO = '0;
      if (CS && RD) begin
         case (ADDR)
            4'd0: DO[NSRC-1:0] = pend;
            4'd1: DO[NSRC-1:0] = imr;
            4'd2: DO[NSRC-1:0] = imode;
            4'd3: DO = {CINT, 3'b000, 4'(lvl_q), 4'b0000, CSRC};
            4'd4, 4'd5, 4'd6, 4'd7: begin
               for (int i = 0; i < NSRC; i++) begin
                  if (ADDR == 4'(4 + i / 4)) begin
                     DO[(i % 4) * 4 +: LVLW] = ilr[i];
                  end
               end
            end
            default: DO = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_fx_itc.sv
// tb/tb_fx_itc.sv - scoreboard bench for fx_itc with a behavioural reference model

module tb_fx_itc;

   localparam int NSRC = 7;
   localparam int LVLW = 3;
   localparam int LMAX = (1 << LVLW) - 1;

   logic            CLK  = 1'b0;
   logic            RESn = 1'b0;
   logic            CE   = 1'b0;
   logic [NSRC-1:0] SRC  = '0;
   logic            CS   = 1'b0;
   logic            WR   = 1'b0;
   logic            RD   = 1'b0;
   logic [3:0]      ADDR = '0;
   logic [15:0]     DI   = '0;
   logic [15:0]     DO;
   logic            CINT;
   logic [LVLW:0]   CINTVn;
   logic [3:0]      CSRC;

   fx_itc #(.NSRC(NSRC), .LVLW(LVLW)) dut (
      .CLK(CLK), .RESn(RESn), .CE(CE), .SRC(SRC), .CS(CS), .WR(WR), .RD(RD),
      .ADDR(ADDR), .DI(DI), .DO(DO), .CINT(CINT), .CINTVn(CINTVn), .CSRC(CSRC)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [15:0]   dout;
      logic          cint;
      logic [LVLW:0] vn;
      logic [3:0]    csrc;
   } exp_t;

   exp_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   // Reference model state
   bit [NSRC-1:0] m_s, m_sd, m_pend, m_imr, m_imode, m_y1, m_y2;
   int            m_ilr [NSRC];
   bit            m_cint;
   int            m_lvl, m_csrc;

   function automatic void model_reset();
      m_s = '0; m_sd = '0; m_pend = '0; m_y1 = '0; m_y2 = '0;
      m_imr = '1; m_imode = '0;
      for (int i = 0; i < NSRC; i++) m_ilr[i] = LMAX - (i % 4);
      m_cint = 0; m_lvl = 0; m_csrc = 0;
   endfunction

   // Advance the model across one clock edge using the inputs applied to it.
   function automatic void model_step();
      bit            found;
      int            nl, ni;
      bit [NSRC-1:0] np;
      bit            wr;
      if (!RESn) begin
         model_reset();
         return;
      end
      if (!CE) return;
      found = 0; nl = 0; ni = 0;
      // Search from the highest level downwards, lowest index first.
      for (int l = LMAX; l >= 1; l--) begin
         for (int i = 0; i < NSRC; i++) begin
            if (!found && m_pend[i] && !m_imr[i] && m_ilr[i] == l) begin
               found = 1; nl = l; ni = i;
            end
         end
      end
      wr = CS && WR;
      for (int i = 0; i < NSRC; i++) begin
         if (wr && ADDR == 2 && DI[i] != m_imode[i]) np[i] = 0;
         else if (m_imode[i]) begin
            if (m_s[i] && !m_sd[i]) np[i] = 1;
            else if (wr && ADDR == 0 && DI[i]) np[i] = 0;
            else np[i] = m_pend[i];
         end else np[i] = m_s[i];
      end
      m_sd = m_s;
`ifdef ITC_SYNC_EN
      m_s  = m_y2;
      m_y2 = m_y1;
      m_y1 = SRC;
`else
      m_s  = SRC;
`endif
      m_pend = np;
      if (wr && ADDR == 1) m_imr = DI[NSRC-1:0];
      if (wr && ADDR == 2) m_imode = DI[NSRC-1:0];
      if (wr && ADDR >= 4 && ADDR <= 7) begin
         for (int k = 0; k < 4; k++) begin
            int idx;
            idx = (int'(ADDR) - 4) * 4 + k;
            if (idx < NSRC) m_ilr[idx] = (int'(DI) >> (4 * k)) & LMAX;
         end
      end
      m_cint = found;
      m_lvl  = found ? nl : 0;
      m_csrc = found ? ni : 0;
   endfunction

   function automatic logic [15:0] model_read();
      int v;
      v = 0;
      if (!(CS && RD)) return 16'h0;
      case (int'(ADDR))
         0: v = int'(m_pend);
         1: v = int'(m_imr);
         2: v = int'(m_imode);
         3: v = (int'(m_cint) << 15) | (m_lvl << 8) | m_csrc;
         4, 5, 6, 7: begin
            for (int k = 0; k < 4; k++) begin
               int idx;
               idx = (int'(ADDR) - 4) * 4 + k;
               if (idx < NSRC) v = v | (m_ilr[idx] << (4 * k));
            end
         end
         default: v = 0;
      endcase
      return 16'(v);
   endfunction

   // One clock: settle the model on the edge just taken, drive new inputs,
   // and queue what the DUT must show before the next edge.
   task automatic cyc(input logic rst, input logic ce, input logic [NSRC-1:0] src,
                      input logic cs, input logic wr, input logic rd,
                      input logic [3:0] addr, input logic [15:0] di);
      exp_t e;
      @(posedge CLK);
      #2;
      model_step();
      RESn = rst; CE = ce; SRC = src; CS = cs; WR = wr; RD = rd; ADDR = addr; DI = di;
      if (!rst) model_reset();
      e.dout = model_read();
      e.cint = m_cint;
      e.vn   = (LVLW+1)'(LMAX - m_lvl);
      e.csrc = 4'(m_csrc);
      exp_q.push_back(e);
   endtask

   task automatic wreg(input logic [3:0] addr, input logic [15:0] di, input logic [NSRC-1:0] src);
      cyc(1'b1, 1'b1, src, 1'b1, 1'b1, 1'b0, addr, di);
   endtask

   task automatic idle(input logic [NSRC-1:0] src, input logic [3:0] addr, input int n);
      for (int i = 0; i < n; i++) cyc(1'b1, 1'b1, src, 1'b1, 1'b0, 1'b1, addr, 16'h0);
   endtask

   // Monitor: checks every queued expectation half a cycle after it was issued.
   initial begin
      exp_t e;
      forever begin
         @(negedge CLK);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_tests += 4;
            if (DO !== e.dout) begin
               n_fail++;
               $display("FAIL DO @%0t addr=%0d: got %h expected %h", $time, ADDR, DO, e.dout);
            end
            if (CINT !== e.cint) begin
               n_fail++;
               $display("FAIL CINT @%0t: got %b expected %b", $time, CINT, e.cint);
            end
            if (CINTVn !== e.vn) begin
               n_fail++;
               $display("FAIL CINTVn @%0t: got %b expected %b", $time, CINTVn, e.vn);
            end
            if (CSRC !== e.csrc) begin
               n_fail++;
               $display("FAIL CSRC @%0t: got %0d expected %0d", $time, CSRC, e.csrc);
            end
         end
      end
   end

   initial begin
      logic [NSRC-1:0] rsrc;
      logic [3:0]      raddr;
      logic [15:0]     rdi;

      // Reset and register readback
      cyc(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0);
      cyc(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0);
      for (int a = 0; a < 5; a++) idle('0, 4'(a), 1);

      // Level source 0
      wreg(4'd1, 16'h007E, '0);
      idle(7'h01, 4'd3, 4);
      idle(7'h00, 4'd3, 3);

      // Edge source 1 with W1C
      wreg(4'd2, 16'h0002, '0);
      wreg(4'd1, 16'h0000, '0);
      idle(7'h02, 4'd0, 1);
      idle(7'h00, 4'd0, 4);
      wreg(4'd0, 16'h0002, '0);
      idle(7'h00, 4'd0, 3);

      // Priority tie and re-prioritisation
      wreg(4'd2, 16'h0000, 7'h44);
      wreg(4'd5, 16'h0500, 7'h44);
      idle(7'h44, 4'd3, 3);
      wreg(4'd5, 16'h0600, 7'h44);
      idle(7'h44, 4'd3, 3);

      // Edge set coinciding with W1C; masked edge then unmask
      wreg(4'd2, 16'h0008, 7'h00);
      idle(7'h00, 4'd0, 2);
      wreg(4'd0, 16'h0008, 7'h08);
      wreg(4'd0, 16'h0008, 7'h00);
      idle(7'h00, 4'd0, 3);
      wreg(4'd0, 16'h0008, 7'h00);
      wreg(4'd1, 16'h0008, 7'h00);
      idle(7'h08, 4'd0, 1);
      idle(7'h00, 4'd3, 3);
      wreg(4'd1, 16'h0000, 7'h00);
      idle(7'h00, 4'd3, 3);

      // Held level source, then asynchronous reset mid-stream
      wreg(4'd2, 16'h0000, 7'h08);
      idle(7'h08, 4'd3, 4);
      cyc(1'b0, 1'b1, 7'h08, 1'b1, 1'b0, 1'b1, 4'd3, 16'h0);
      cyc(1'b0, 1'b1, 7'h08, 1'b1, 1'b0, 1'b1, 4'd1, 16'h0);
      idle(7'h08, 4'd3, 6);

      // Randomised traffic
      rsrc = '0;
      for (int n = 0; n < 4000; n++) begin
         if ($urandom_range(0, 9) < 3) rsrc = NSRC'($urandom);
         raddr = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
         rdi = 16'($urandom);
         if (raddr == 4'd1 && $urandom_range(0, 1) == 1) rdi = 16'h0000;
         cyc(($urandom_range(0, 599) != 0), ($urandom_range(0, 9) != 0), rsrc,
             ($urandom_range(0, 9) != 0), ($urandom_range(0, 9) < 2),
             ($urandom_range(0, 9) < 7), raddr, rdi);
      end

      @(negedge CLK);
      @(negedge CLK);
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d pending expectations, required 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
